keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_MAX, default 15: the largest accepted hold value, in scans (4-bit field).
REQ-002 Parameter RELEASE_SCANS, default 2: the number of target-column scans held released before done.
REQ-003 Parameter BOUNCE_CYCLES, default 8: the number of clocks of contact-bounce emulation.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port cols, input, 4: column strobes from the scanner; one-hot, active high.
REQ-007 Port rows, output, 4: row sense lines to the scanner; active high.
REQ-008 Port req_valid, input, 1: a press request is offered.
REQ-009 Port req_ready, output, 1: the block can accept a request.
REQ-010 Port req_key, input, 4: key code; row = req_key[3:2], column = req_key[1:0].
REQ-011 Port req_hold, input, 4: number of target-column scans the key stays pressed.
REQ-012 Port busy, output, 1: a request is in progress.
REQ-013 Port done, output, 1: one-cycle pulse when a request completes.

Function
REQ-014 The FSM SHALL have the states IDLE, BOUNCE, PRESS, RELEASE and DONE.
REQ-015 req_ready SHALL be 1 only in IDLE; busy SHALL be 1 in every other state.
REQ-016 A request SHALL be accepted on the cycle req_valid && req_ready; req_key and req_hold are latched that cycle, and later input changes are ignored.
REQ-017 After acceptance, the FSM SHALL go IDLE->BOUNCE when bouncing is compiled in, else IDLE->PRESS.
REQ-018 A req_hold value of 0 SHALL be treated as 1.
REQ-019 A scan event SHALL be a 0->1 transition of cols[latched column], detected against a registered copy of cols.
REQ-020 PRESS SHALL count scan events and move to RELEASE on the cycle the count reaches the latched hold.
REQ-021 RELEASE SHALL count RELEASE_SCANS scan events, then move to DONE.
REQ-022 DONE SHALL last exactly one cycle, assert done, and return to IDLE; a request cannot be accepted during DONE.
REQ-023 rows SHALL equal one-hot(latched row) when the pressed flag = 1 and cols[latched column] = 1, and 0 otherwise.
REQ-024 The cols->rows path SHALL be combinational (zero latency); it is the only combinational input-to-output path.
REQ-025 The pressed flag SHALL be 1 throughout PRESS and 0 in IDLE, RELEASE and DONE.
REQ-026 Strobes on non-target columns, or cols with several bits set, SHALL NOT count as scan events; rows still follow REQ-023.
REQ-027 The scan counters SHALL be 4-bit and saturate; they are cleared on state entry.

Reset
REQ-028 On a clock edge with reset = 1, the block SHALL enter IDLE and clear all counters, the latched key, the latched hold and the cols register.
REQ-029 After reset, rows = 0, req_ready = 1, busy = 0 and done = 0.
REQ-030 Reset mid-request SHALL abort the request without a done pulse.
REQ-031 Reset SHALL take priority over a simultaneous request.

Configuration
REQ-032 The macro KEYPAD_EMU_BOUNCE_EN SHALL control bounce emulation.
REQ-033 When KEYPAD_EMU_BOUNCE_EN is defined, BOUNCE SHALL last BOUNCE_CYCLES clocks:
- the pressed flag starts at 1 and toggles every clock;
- the block then moves to PRESS;
- bounce cycles are not counted toward req_hold.
REQ-034 When KEYPAD_EMU_BOUNCE_EN is undefined, the BOUNCE state, its counter and the BOUNCE_CYCLES logic SHALL NOT be built.

Structure
REQ-035 The shared package keypad_emu_pkg SHALL hold:
- the FSM state enum;
- the key-code field widths and positions (row bits 3:2, column bits 1:0);
- the one-hot decode function.
REQ-036 The sub-module scan_edge_counter SHALL provide column edge detection plus a saturating count with clear, and SHALL be instantiated once.

Verification
REQ-037 Reset: hold reset for 2 cycles, then release -> rows = 0, req_ready = 1, busy = 0, done = 0.
REQ-038 Basic press: request key 0x9, hold 3, no bounce; scanner rotates cols 0001->0010->0100->1000 at 4 clocks per column ->
- rows = 0100 only while cols = 0010, for 3 scans;
- then rows = 0 for 2 scans;
- then one done pulse, and req_ready returns to 1.
REQ-039 Hold 0: request key 0x0, hold 0 -> exactly one scan with rows = 0001 while cols = 0001.
REQ-040 Multi-hot cols: drive cols = 1111 throughout with key 0x5 -> rows = 0010 while pressed, with no early exit from PRESS.
REQ-041 Mid-press reset: assert reset during the second scan of hold 3 -> rows = 0 after that edge, and no done pulse.
REQ-042 Bounce build: with KEYPAD_EMU_BOUNCE_EN and BOUNCE_CYCLES = 8, static cols = 0001 and key 0x0 -> rows toggles 1,0,1,0,... for 8 clocks, then the PRESS counting proceeds normally.

Source files
------------

// File: rtl/keypad_emu_pkg.sv
// Shared definitions for the keypad emulator: FSM states, key-code fields, one-hot decode.
package keypad_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BOUNCE  = 3'd1,
    ST_PRESS   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int LINES   = 4;
  localparam int CNT_W   = 4;
  localparam int KEY_W   = 4;
  localparam int ROW_W   = 2;
  localparam int ROW_LSB = 2;
  localparam int COL_W   = 2;
  localparam int COL_LSB = 0;

  function automatic logic [LINES-1:0] onehot(input logic [1:0] idx);
    logic [LINES-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_edge_counter.sv
// Rising-edge detector on one selected column strobe with a saturating, clearable scan count.
module scan_edge_counter
  import keypad_emu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [LINES-1:0] cols,
  input  logic [COL_W-1:0] col_sel,
  input  logic             clear,
  output logic             scan,
  output logic [CNT_W-1:0] count
);

  logic [LINES-1:0] cols_q;

  // Only a clean single-column strobe on the selected column counts as a scan.
  always_comb begin
    scan = (cols == onehot(col_sel)) && !cols_q[col_sel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cols_q <= '0;
      count  <= '0;
    end else begin
      cols_q <= cols;
      if (clear) begin
        count <= '0;
      end else if (scan && (count != '1)) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a single key press on a scanned 4x4 matrix. Optional contact bounce is
// built when the macro KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator
  import keypad_emu_pkg::*;
#(
  parameter int HOLD_MAX      = 15,
  parameter int RELEASE_SCANS = 2,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LINES-1:0] cols,
  output logic [LINES-1:0] rows,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [KEY_W-1:0] req_key,
  input  logic [CNT_W-1:0] req_hold,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W:0]   REL_LIMIT  = (CNT_W+1)'(RELEASE_SCANS);

  if (BOUNCE_CYCLES < 1) begin : g_bounce_chk
    $error("BOUNCE_CYCLES must be at least 1");
  end
  if (RELEASE_SCANS < 1) begin : g_release_chk
    $error("RELEASE_SCANS must be at least 1");
  end

  state_t           state;
  state_t           state_next;
  logic [ROW_W-1:0] key_row;
  logic [COL_W-1:0] key_col;
  logic [CNT_W-1:0] hold;
  logic             accept;
  logic             pressed;
  logic             scan;
  logic             clear;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  // Zero hold means one scan; anything above HOLD_MAX is clamped.
  function automatic logic [CNT_W-1:0] eff_hold(input logic [CNT_W-1:0] h);
    if (h == '0) begin
      return CNT_W'(1);
    end else if (h > HOLD_LIMIT) begin
      return HOLD_LIMIT;
    end else begin
      return h;
    end
  endfunction

  assign req_ready = (state == ST_IDLE);
  assign busy      = !req_ready;
  assign done      = (state == ST_DONE);
  assign accept    = req_valid && req_ready;
  assign count_inc = {1'b0, count} + 1'b1;
  assign clear     = (state_next != state);

  scan_edge_counter u_scan (
    .clk     (clk),
    .reset   (reset),
    .cols    (cols),
    .col_sel (key_col),
    .clear   (clear),
    .scan    (scan),
    .count   (count)
  );

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
  localparam logic [BW-1:0] BOUNCE_LAST = BW'(BOUNCE_CYCLES - 1);
  localparam state_t START_STATE = ST_BOUNCE;

  logic [BW-1:0] bounce_cnt;
  logic          bounce_phase;

  // Phase is preset to 1 outside BOUNCE so the first bounce clock reads as pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      bounce_cnt   <= '0;
      bounce_phase <= 1'b1;
    end else if (state != ST_BOUNCE) begin
      bounce_cnt   <= '0;
      bounce_phase <= 1'b1;
    end else begin
      bounce_cnt   <= bounce_cnt + 1'b1;
      bounce_phase <= !bounce_phase;
    end
  end

  assign pressed = (state == ST_PRESS) || ((state == ST_BOUNCE) && bounce_phase);
`else
  localparam state_t START_STATE = ST_PRESS;

  assign pressed = (state == ST_PRESS);
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (accept) state_next = START_STATE;
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE:  if (bounce_cnt == BOUNCE_LAST) state_next = ST_PRESS;
`endif
      ST_PRESS:   if (scan && (count_inc >= {1'b0, hold})) state_next = ST_RELEASE;
      ST_RELEASE: if (scan && (count_inc >= REL_LIMIT)) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      key_row <= '0;
      key_col <= '0;
      hold    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        key_row <= req_key[ROW_LSB +: ROW_W];
        key_col <= req_key[COL_LSB +: COL_W];
        hold    <= eff_hold(req_hold);
      end
    end
  end

  // Zero-latency row response to the scanner's column strobe.
  assign rows = (pressed && cols[key_col]) ? onehot(key_row) : '0;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator; the bounce scenario runs when
// KEYPAD_EMU_BOUNCE_EN is defined, the press/hold/multi-hot/reset scenarios otherwise.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_key;
  logic [3:0] req_hold;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  keypad_emulator #(
    .HOLD_MAX      (15),
    .RELEASE_SCANS (2),
    .BOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_hold  (req_hold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given strobe; rows and done checked mid-cycle.
  task automatic step(input logic [3:0] c, input logic [3:0] exp_rows, input logic exp_done,
                      input string tag);
    cols = c;
    @(negedge clk);
    check({tag, ".rows"}, rows, exp_rows);
    check({tag, ".done"}, {3'b000, done}, {3'b000, exp_done});
    adv();
  endtask

  // One scanner rotation: each column strobed for 4 clocks, columns 0..3.
  task automatic rot(input logic [3:0] tgt, input logic [3:0] first, input logic [3:0] rest,
                     input int done_idx, input string tag);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] c;
      logic [3:0] e;
      c = 4'b0001 << (i / 4);
      e = (c == tgt) ? (((i % 4) == 0) ? first : rest) : 4'b0000;
      step(c, e, (i == done_idx), $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, ".ready"}, {3'b000, req_ready}, 4'd1);
    check({tag, ".busy"},  {3'b000, busy},      4'd0);
    check({tag, ".done"},  {3'b000, done},      4'd0);
    check({tag, ".rows"},  rows,                4'b0000);
    adv();
  endtask

  task automatic offer(input logic [3:0] c, input logic [3:0] key, input logic [3:0] hold,
                       input string tag);
    cols      = c;
    req_valid = 1'b1;
    req_key   = key;
    req_hold  = hold;
    @(negedge clk);
    check({tag, ".ready"}, {3'b000, req_ready}, 4'd1);
    adv();
    req_valid = 1'b0;
    req_key   = 4'hF;
    req_hold  = 4'h1;
  endtask

  initial begin
    reset     = 1'b1;
    cols      = 4'b0000;
    req_valid = 1'b0;
    req_key   = 4'h0;
    req_hold  = 4'h0;
    adv();
    adv();
    reset = 1'b0;
    check_idle("reset");

`ifdef KEYPAD_EMU_BOUNCE_EN
    offer(4'b0001, 4'h0, 4'd1, "bnc.req");
    for (int k = 0; k < 8; k++) begin
      step(4'b0001, ((k % 2) == 0) ? 4'b0001 : 4'b0000, 1'b0, $sformatf("bnc.b%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 4'b0001, 1'b0, $sformatf("bnc.p%0d", k));
    end
    step(4'b0000, 4'b0000, 1'b0, "bnc.gap0");
    step(4'b0001, 4'b0001, 1'b0, "bnc.scan1");
    step(4'b0001, 4'b0000, 1'b0, "bnc.rel0");
    step(4'b0000, 4'b0000, 1'b0, "bnc.gap1");
    step(4'b0001, 4'b0000, 1'b0, "bnc.rel1");
    step(4'b0000, 4'b0000, 1'b0, "bnc.gap2");
    step(4'b0001, 4'b0000, 1'b0, "bnc.rel2");
    step(4'b0000, 4'b0000, 1'b1, "bnc.done");
    check_idle("bnc.end");
`else
    // Basic press: key 0x9 (row 2, column 1), hold 3.
    offer(4'b0001, 4'h9, 4'd3, "basic.req");
    cols = 4'b0001;
    @(negedge clk);
    check("basic.busy",  {3'b000, busy},      4'd1);
    check("basic.ready", {3'b000, req_ready}, 4'd0);
    adv();
    rot(4'b0010, 4'b0100, 4'b0100, -1, "basic.s1");
    rot(4'b0010, 4'b0100, 4'b0100, -1, "basic.s2");
    rot(4'b0010, 4'b0100, 4'b0000, -1, "basic.s3");
    rot(4'b0010, 4'b0000, 4'b0000, -1, "basic.r1");
    rot(4'b0010, 4'b0000, 4'b0000, 5,  "basic.r2");
    check_idle("basic.end");

    // Hold 0 behaves as hold 1: key 0x0 (row 0, column 0).
    offer(4'b0010, 4'h0, 4'd0, "hold0.req");
    rot(4'b0001, 4'b0001, 4'b0000, -1, "hold0.s1");
    rot(4'b0001, 4'b0000, 4'b0000, -1, "hold0.r1");
    rot(4'b0001, 4'b0000, 4'b0000, 1,  "hold0.r2");
    check_idle("hold0.end");

    // Multi-hot strobes never count: key 0x5 (row 1, column 1) stays in PRESS.
    offer(4'b1111, 4'h5, 4'd2, "multi.req");
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 4'b0010, 1'b0, $sformatf("multi[%0d]", k));
    end
    @(negedge clk);
    check("multi.busy", {3'b000, busy}, 4'd1);
    adv();
    reset = 1'b1;
    adv();
    reset = 1'b0;
    check_idle("multi.reset");

    // Reset during the second scan aborts; a request offered alongside reset is dropped.
    offer(4'b0001, 4'h9, 4'd3, "abort.req");
    rot(4'b0010, 4'b0100, 4'b0100, -1, "abort.s1");
    for (int k = 0; k < 4; k++) begin
      step(4'b0001, 4'b0000, 1'b0, $sformatf("abort.c0[%0d]", k));
    end
    step(4'b0010, 4'b0100, 1'b0, "abort.s2");
    reset     = 1'b1;
    req_valid = 1'b1;
    req_key   = 4'h9;
    req_hold  = 4'd3;
    @(negedge clk);
    check("abort.pre_rows", rows, 4'b0100);
    adv();
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort.rows",  rows,                4'b0000);
    check("abort.ready", {3'b000, req_ready}, 4'd1);
    check("abort.busy",  {3'b000, busy},      4'd0);
    adv();
    rot(4'b0010, 4'b0000, 4'b0000, -1, "abort.after");
    check_idle("abort.end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
